skolem_exhaustive_checker: RTL

//   Sequential harness downstream of a synthesized combinational Skolem function.

---
 rtl/skolem_exhaustive_checker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/skolem_exhaustive_checker.sv
`default_nettype none
// ============================================================================
//  Module      : skolem_exhaustive_checker
//  Description : Exhaustive sweep harness for a synthesized Skolem candidate.
//                Walks every N_IN-bit assignment, samples the candidate
//                output after LAT settle cycles and checks the relation
//                (^inputs) ^ output == SPEC_PARITY. Reports pass/fail, the
//                number of failing assignments and the first failing one.
//  Revision    : 1.0  initial release
// ============================================================================
module skolem_exhaustive_checker #(
  parameter int   N_IN        = 4,
  parameter int   LAT         = 0,
  parameter logic SPEC_PARITY = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            stop_on_fail_i,
  output logic [N_IN-1:0] cand_in_o,
  input  logic            cand_out_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   fail_cnt_o,
  output logic [N_IN-1:0] first_fail_vec_o,
  output logic            first_fail_valid_o
);

  // State encoding
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_DRIVE = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_CHECK = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  // Wait counter sizing; a 1-bit counter is kept even when LAT is 0 so the
  // datapath stays uniform (WAIT is simply never entered in that case).
  localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int LAT_M1 = (LAT > 0) ? (LAT - 1) : 0;
  localparam logic [WAIT_W-1:0] c_LAT_LAST = WAIT_W'(LAT_M1);
  localparam logic              c_HAS_WAIT = (LAT > 0);

  // 2^N_IN: the largest possible failure count, fits exactly in N_IN+1 bits
  localparam logic [N_IN:0] c_FAIL_MAX = {1'b1, {N_IN{1'b0}}};

  logic [2:0]        state_q,     state_d;
  logic [N_IN-1:0]   cand_in_q,   cand_in_d;
  logic [WAIT_W-1:0] wait_q,      wait_d;
  logic [N_IN:0]     fail_cnt_q,  fail_cnt_d;
  logic [N_IN-1:0]   ff_vec_q,    ff_vec_d;
  logic              ff_valid_q,  ff_valid_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              pass_q,      pass_d;
  logic              stop_q,      stop_d;

  logic              w_ok;
  logic              w_last_vec;
  logic              w_end_sweep;
  logic              w_accept;

  // Relation check against the current assignment and the sweep end condition
  assign w_ok        = (((^cand_in_q) ^ cand_out_i) == SPEC_PARITY);
  assign w_last_vec  = &cand_in_q;
  assign w_end_sweep = w_last_vec || (!w_ok && stop_q);
  assign w_accept    = start_i && ((state_q == c_ST_IDLE) || (state_q == c_ST_DONE));

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= c_ST_IDLE;
      cand_in_q  <= '0;
      wait_q     <= '0;
      fail_cnt_q <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_in_q  <= cand_in_d;
      wait_q     <= wait_d;
      fail_cnt_q <= fail_cnt_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      stop_q     <= stop_d;
    end
  end

  // Next-state logic: DRIVE -> (WAIT x LAT) -> CHECK per assignment
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE,
      c_ST_DONE:  if (start_i) state_d = c_ST_DRIVE;
      c_ST_DRIVE: state_d = c_HAS_WAIT ? c_ST_WAIT : c_ST_CHECK;
      c_ST_WAIT:  if (wait_q == c_LAT_LAST) state_d = c_ST_CHECK;
      c_ST_CHECK: state_d = w_end_sweep ? c_ST_DONE : c_ST_DRIVE;
      default:    state_d = c_ST_IDLE;
    endcase
  end

  // Output/datapath next values: sweep setup, settle counting, result capture
  always_comb begin
    cand_in_d  = cand_in_q;
    wait_d     = wait_q;
    fail_cnt_d = fail_cnt_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    stop_d     = stop_q;

    if (w_accept) begin
      // A start in DONE restarts immediately and drops done in the same cycle
      cand_in_d  = '0;
      wait_d     = '0;
      fail_cnt_d = '0;
      ff_vec_d   = '0;
      ff_valid_d = 1'b0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      stop_d     = stop_on_fail_i;
      busy_d     = 1'b1;
    end else begin
      case (state_q)
        c_ST_DRIVE: wait_d = '0;
        c_ST_WAIT:  wait_d = wait_q + WAIT_W'(1);
        c_ST_CHECK: begin
          if (!w_ok) begin
            if (fail_cnt_q != c_FAIL_MAX) fail_cnt_d = fail_cnt_q + (N_IN+1)'(1);
            if (!ff_valid_q) begin
              ff_vec_d   = cand_in_q;
              ff_valid_d = 1'b1;
            end
          end
          if (w_end_sweep) begin
            // cand_in is left on the last checked assignment; it never wraps
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (fail_cnt_d == '0);
          end else begin
            cand_in_d = cand_in_q + N_IN'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cand_in_o          = cand_in_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign fail_cnt_o         = fail_cnt_q;
  assign first_fail_vec_o   = ff_vec_q;
  assign first_fail_valid_o = ff_valid_q;

endmodule
`default_nettype wire
